// File: rtl/mem_arbiter_if.sv
// Bundle of every cache-side and memory-side signal that passes through the
// memory arbiter. The arbiter takes the slave view; the environment (both
// caches plus data_memory) takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // dcache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;

    // icache side (read only)
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;

    // data_memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    modport master (
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        output i_read, i_address,
        input  i_readdata, i_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

    modport slave (
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        input  i_read, i_address,
        output i_readdata, i_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data_memory between the icache and dcache.
// The granted cache's strobes, address and data are forwarded to memory; the
// losing cache simply sees its own request reflected back as BUSYWAIT, so it
// stalls without any change to its existing handshake.
module mem_arbiter (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } state_t;

    state_t     state;
    logic       started;   // memory has raised busywait for the current grant
    logic       prio;      // 0: dcache preferred, 1: icache preferred
    logic [1:0] lock;      // bit0 locks dcache, bit1 locks icache, for one idle cycle

    logic d_req;
    logic i_req;
    logic d_elig;
    logic i_elig;

    assign d_req  = bus.d_read | bus.d_write;
    assign i_req  = bus.i_read;
    assign d_elig = d_req & ~lock[0];
    assign i_elig = i_req & ~lock[1];

    // Read data is shared; each cache only samples it once its BUSYWAIT drops.
    assign bus.d_readdata = bus.mem_readdata;
    assign bus.i_readdata = bus.mem_readdata;

    // Grant decision, transfer tracking and round-robin/lockout bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            started <= 1'b0;
            prio    <= 1'b0;
            lock    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    // The lockout only ever lasts a single idle cycle, otherwise a
                    // lone requester that was just served could never be re-granted.
                    lock <= 2'b00;
                    if (d_elig && (!i_elig || !prio)) begin
                        state   <= SERVE_D;
                        started <= 1'b0;
                    end else if (i_elig) begin
                        state   <= SERVE_I;
                        started <= 1'b0;
                    end
                end
                SERVE_D, SERVE_I: begin
                    if (bus.mem_busywait) begin
                        started <= 1'b1;
                    end else if (started) begin
                        state <= IDLE;
                        prio  <= (state == SERVE_D);
                        lock  <= (state == SERVE_D) ? 2'b01 : 2'b10;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Forward the granted cache to memory and build both BUSYWAITs; all of it
    // is forced quiet while reset is held so nothing leaks into memory.
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        bus.d_busywait    = 1'b0;
        bus.i_busywait    = 1'b0;
        if (!rst) begin
            bus.d_busywait = d_req;
            bus.i_busywait = i_req;
            case (state)
                SERVE_D: begin
                    bus.mem_write     = bus.d_write;
                    bus.mem_read      = bus.d_read & ~bus.d_write;
                    bus.mem_address   = bus.d_address;
                    bus.mem_writedata = bus.d_writedata;
                    bus.d_busywait    = started ? bus.mem_busywait : 1'b1;
                end
                SERVE_I: begin
                    bus.mem_read      = bus.i_read;
                    bus.mem_address   = bus.i_address;
                    bus.i_busywait    = started ? bus.mem_busywait : 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
